// File: rtl/ks_i2s_tx.sv
// I2S transmitter: 64-bck frame, 24-bit MSB-first samples, lrck derived from bck; optional KS_STEREO_EN.
// Latency: latch on edge entering k=0, left MSB 1 bck later, right MSB 33 bck later.
// Backpressure: none; req is a one-bck strobe per frame and samples are never stalled.
module ks_i2s_tx (
  input  logic        bck,
  input  logic        rst_n,
  input  logic [23:0] in_l,
  input  logic [23:0] in_r,
  input  logic        mute,
  output logic        lrck,
  output logic        sdata,
  output logic        req
);

  logic [5:0]  cnt;
  logic [5:0]  cnt_nxt;
  logic        latch;
  logic [23:0] hold_l;
  logic [23:0] right_word;
  logic [5:0]  bit_idx;
  logic        sdata_nxt;

  assign cnt_nxt = cnt + 6'd1;
  assign latch   = (cnt_nxt == 6'd0);

`ifdef KS_STEREO_EN
  logic [23:0] hold_r;

  // Right hold register: captures in_r (or zero when muted) at the frame latch.
  always_ff @(negedge bck or negedge rst_n) begin
    if (!rst_n) begin
      hold_r <= 24'd0;
    end else if (latch) begin
      hold_r <= mute ? 24'd0 : in_r;
    end
  end

  assign right_word = hold_r;
`else
  // Mono build: right slot repeats the latched left word; in_r is not used.
  logic unused_in_r;
  assign unused_in_r = ^in_r;
  assign right_word  = hold_l;
`endif

  // Frame counter: reset parks at 63 so the first edge after release enters k=0.
  always_ff @(negedge bck or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 6'd63;
    end else begin
      cnt <= cnt_nxt;
    end
  end

  // Left hold register: only changes at the frame latch.
  always_ff @(negedge bck or negedge rst_n) begin
    if (!rst_n) begin
      hold_l <= 24'd0;
    end else if (latch) begin
      hold_l <= mute ? 24'd0 : in_l;
    end
  end

  // Select the serial bit for the slot being entered; one-bit delay after each lrck edge.
  always_comb begin
    sdata_nxt = 1'b0;
    bit_idx   = 6'd0;
    if (cnt_nxt >= 6'd1 && cnt_nxt <= 6'd24) begin
      bit_idx   = 6'd24 - cnt_nxt;
      sdata_nxt = hold_l[bit_idx[4:0]];
    end else if (cnt_nxt >= 6'd33 && cnt_nxt <= 6'd56) begin
      bit_idx   = 6'd56 - cnt_nxt;
      sdata_nxt = right_word[bit_idx[4:0]];
    end
  end

  // Registered outputs so lrck, sdata and req all change together on the falling edge.
  always_ff @(negedge bck or negedge rst_n) begin
    if (!rst_n) begin
      lrck  <= 1'b1;
      sdata <= 1'b0;
      req   <= 1'b0;
    end else begin
      lrck  <= cnt_nxt[5];
      sdata <= sdata_nxt;
      req   <= latch;
    end
  end

endmodule

// File: tb/tb_ks_i2s_tx.sv
// Directed bench for ks_i2s_tx: captures whole frames on the rising edge of bck
// and compares them against frames built from the hand-chosen sample words.
// Expected right-slot contents depend on whether KS_STEREO_EN is defined.
module tb_ks_i2s_tx;

  logic        bck;
  logic        rst_n;
  logic [23:0] in_l;
  logic [23:0] in_r;
  logic        mute;
  logic        lrck;
  logic        sdata;
  logic        req;

  int checks;
  int failures;

  localparam logic [63:0] LRCK_EXP = 64'hFFFF_FFFF_0000_0000;
  localparam logic [63:0] REQ_EXP  = 64'h0000_0000_0000_0001;

  ks_i2s_tx dut (
    .bck   (bck),
    .rst_n (rst_n),
    .in_l  (in_l),
    .in_r  (in_r),
    .mute  (mute),
    .lrck  (lrck),
    .sdata (sdata),
    .req   (req)
  );

  initial begin
    bck = 1'b1;
    forever #5 bck = ~bck;
  end

  // Expected sdata for a frame: bit k of the result is sdata at frame position k.
  function automatic logic [63:0] exp_frame(input logic [23:0] l, input logic [23:0] r);
    logic [63:0] f;
    f = 64'd0;
    for (int k = 1; k <= 24; k++) f[k] = l[24-k];
    for (int k = 33; k <= 56; k++) f[k] = r[56-k];
    return f;
  endfunction

  function automatic logic [23:0] right_exp(input logic [23:0] l, input logic [23:0] r);
`ifdef KS_STEREO_EN
    return r;
`else
    return l;
`endif
  endfunction

  // Sample n positions starting at k=0; optionally change in_l after sampling position chg_k.
  task automatic capture(input int n, input int chg_k, input logic [23:0] chg_val,
                         output logic [63:0] sd, output logic [63:0] lr, output logic [63:0] rq);
    sd = 64'd0; lr = 64'd0; rq = 64'd0;
    for (int k = 0; k < n; k++) begin
      @(posedge bck);
      sd[k] = sdata;
      lr[k] = lrck;
      rq[k] = req;
      if (k == chg_k) in_l = chg_val;
    end
  endtask

  task automatic test_reset();
    logic [63:0] sd, lr, rq, e;
    rst_n = 1'b0; in_l = 24'h800001; in_r = 24'h000000; mute = 1'b0;
    @(posedge bck);
    checks++; if (lrck !== 1'b1) begin failures++; $display("FAIL reset_lrck got=%b want=1", lrck); end
    checks++; if (sdata !== 1'b0) begin failures++; $display("FAIL reset_sdata got=%b want=0", sdata); end
    checks++; if (req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b want=0", req); end
    rst_n = 1'b1;
    capture(64, -1, 24'd0, sd, lr, rq);
    e = exp_frame(24'h800001, right_exp(24'h800001, 24'h000000));
    checks++; if (rq !== REQ_EXP) begin failures++; $display("FAIL first_req got=%h want=%h", rq, REQ_EXP); end
    checks++; if (lr !== LRCK_EXP) begin failures++; $display("FAIL first_lrck got=%h want=%h", lr, LRCK_EXP); end
    checks++; if (sd !== e) begin failures++; $display("FAIL first_sdata got=%h want=%h", sd, e); end
  endtask

  task automatic test_channels();
    logic [63:0] sd, lr, rq, e;
    in_l = 24'hA5A5A5; in_r = 24'h5A5A5A;
    capture(64, -1, 24'd0, sd, lr, rq);
    e = exp_frame(24'hA5A5A5, right_exp(24'hA5A5A5, 24'h5A5A5A));
    checks++; if (sd !== e) begin failures++; $display("FAIL chan_sdata got=%h want=%h", sd, e); end
    checks++; if (rq !== REQ_EXP) begin failures++; $display("FAIL chan_req got=%h want=%h", rq, REQ_EXP); end
    checks++; if (lr !== LRCK_EXP) begin failures++; $display("FAIL chan_lrck got=%h want=%h", lr, LRCK_EXP); end
  endtask

  task automatic test_input_hold();
    logic [63:0] sd, lr, rq, e;
    capture(64, 10, 24'h000000, sd, lr, rq);
    e = exp_frame(24'hA5A5A5, right_exp(24'hA5A5A5, 24'h5A5A5A));
    checks++; if (sd !== e) begin failures++; $display("FAIL hold_inflight got=%h want=%h", sd, e); end
    capture(64, -1, 24'd0, sd, lr, rq);
    e = exp_frame(24'h000000, right_exp(24'h000000, 24'h5A5A5A));
    checks++; if (sd !== e) begin failures++; $display("FAIL hold_next got=%h want=%h", sd, e); end
  endtask

  task automatic test_mute();
    logic [63:0] sd, lr, rq, e;
    in_l = 24'h7FFFFF; in_r = 24'h7FFFFF; mute = 1'b1;
    capture(64, -1, 24'd0, sd, lr, rq);
    checks++; if (sd !== 64'd0) begin failures++; $display("FAIL mute_frame got=%h want=0", sd); end
    checks++; if (rq !== REQ_EXP) begin failures++; $display("FAIL mute_req got=%h want=%h", rq, REQ_EXP); end
    mute = 1'b0;
    capture(64, -1, 24'd0, sd, lr, rq);
    e = exp_frame(24'h7FFFFF, 24'h7FFFFF);
    checks++; if (sd !== e) begin failures++; $display("FAIL unmute_frame got=%h want=%h", sd, e); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] sd, lr, rq, e, pe;
    capture(41, -1, 24'd0, sd, lr, rq);
    pe = exp_frame(24'h7FFFFF, 24'h7FFFFF);
    checks++; if (sd[40:0] !== pe[40:0]) begin failures++; $display("FAIL partial_sdata got=%h want=%h", sd[40:0], pe[40:0]); end
    rst_n = 1'b0;
    #1;
    checks++; if (sdata !== 1'b0) begin failures++; $display("FAIL midrst_sdata got=%b want=0", sdata); end
    for (int i = 0; i < 3; i++) begin
      @(posedge bck);
      checks++; if (lrck !== 1'b1) begin failures++; $display("FAIL midrst_lrck[%0d] got=%b want=1", i, lrck); end
      checks++; if (sdata !== 1'b0) begin failures++; $display("FAIL midrst_sdata[%0d] got=%b want=0", i, sdata); end
      checks++; if (req !== 1'b0) begin failures++; $display("FAIL midrst_req[%0d] got=%b want=0", i, req); end
    end
    in_l = 24'h123456; in_r = 24'hFEDCBA;
    rst_n = 1'b1;
    capture(64, -1, 24'd0, sd, lr, rq);
    e = exp_frame(24'h123456, right_exp(24'h123456, 24'hFEDCBA));
    checks++; if (rq !== REQ_EXP) begin failures++; $display("FAIL restart_req got=%h want=%h", rq, REQ_EXP); end
    checks++; if (lr !== LRCK_EXP) begin failures++; $display("FAIL restart_lrck got=%h want=%h", lr, LRCK_EXP); end
    checks++; if (sd !== e) begin failures++; $display("FAIL restart_sdata got=%h want=%h", sd, e); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_channels();
    test_input_hold();
    test_mute();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
